// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard detection and operand forwarding control for a classic 5-stage MIPS
// pipeline (IF/ID/EX/MEM/WB). The block sits beside the decode stage. It keeps
// its own shadow copy of the destination register, write-enable and load flag
// of the instructions currently in EX, MEM and WB. From that copy it decides:
//   - which bypass source feeds the rs / rt operands of the decoding
//     instruction,
//   - whether a load-use hazard forces a one-cycle stall with a bubble
//     injected into ID/EX,
//   - how many stall cycles have occurred (saturating counter).
//
// Ports
//   i_clk           rising-edge clock
//   i_resetn        synchronous active-low reset
//   i_d_rs          ID rs field
//   i_d_rt          ID rt field
//   i_d_dest        ID destination register (after the rt/rd mux)
//   i_d_wreg        ID instruction writes the register file
//   i_d_m2reg       ID instruction is a load
//   i_d_use_rs      ID instruction reads rs
//   i_d_use_rt      ID instruction reads rt
//   i_freeze        global pipeline freeze
//   o_fwda          rs operand select (00 regfile, 01 EX ALU, 10 MEM ALU,
//                   11 MEM load data)
//   o_fwdb          rt operand select, same encoding
//   o_stall         load-use stall this cycle
//   o_pc_wen        PC write enable
//   o_ifid_wen      IF/ID register write enable
//   o_e_bubble      insert a NOP into ID/EX this cycle
//   o_stall_count   saturating count of stall cycles
//   o_w_dest        WB-stage tracked destination (debug visibility)
//   o_w_wreg        WB-stage tracked write enable (debug visibility)
//   o_w_m2reg       WB-stage tracked load flag (debug visibility)
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic [4:0]             i_d_rs,
  input  logic [4:0]             i_d_rt,
  input  logic [4:0]             i_d_dest,
  input  logic                   i_d_wreg,
  input  logic                   i_d_m2reg,
  input  logic                   i_d_use_rs,
  input  logic                   i_d_use_rt,
  input  logic                   i_freeze,
  output logic [1:0]             o_fwda,
  output logic [1:0]             o_fwdb,
  output logic                   o_stall,
  output logic                   o_pc_wen,
  output logic                   o_ifid_wen,
  output logic                   o_e_bubble,
  output logic [STALL_CNT_W-1:0] o_stall_count,
  output logic [4:0]             o_w_dest,
  output logic                   o_w_wreg,
  output logic                   o_w_m2reg
);

  // Operand source encoding shared by both forwarding selects.
  typedef enum logic [1:0] {
    FWD_REGFILE  = 2'b00,
    FWD_EX_ALU   = 2'b01,
    FWD_MEM_ALU  = 2'b10,
    FWD_MEM_LOAD = 2'b11
  } fwd_sel_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // Shadow pipeline tracking registers for EX, MEM and WB.
  logic [4:0]             r_e_dest;
  logic                   r_e_wreg;
  logic                   r_e_m2reg;
  logic [4:0]             r_m_dest;
  logic                   r_m_wreg;
  logic                   r_m_m2reg;
  logic [4:0]             r_w_dest;
  logic                   r_w_wreg;
  logic                   r_w_m2reg;
  logic [STALL_CNT_W-1:0] r_stall_count;

  // Per-operand match flags and derived control.
  logic     w_e_hit_rs;
  logic     w_e_hit_rt;
  logic     w_m_hit_rs;
  logic     w_m_hit_rt;
  logic     w_load_use_rs;
  logic     w_load_use_rt;
  logic     w_stall;
  logic     w_advance;
  logic     w_cnt_sat;
  fwd_sel_t w_fwda;
  fwd_sel_t w_fwdb;

  // A stage only counts as a producer of r when it really writes r. Register
  // $0 is hardwired to zero, so a "write" to it never creates a dependency.
  function automatic logic stageWrites(input logic       wreg,
                                       input logic [4:0] dest,
                                       input logic [4:0] r);
    return wreg && (dest == r) && (r != 5'd0);
  endfunction

  // Source selection for one operand. EX is younger than MEM, so it wins when
  // both write the same register. A load in EX cannot be bypassed yet; in that
  // case the select falls through to MEM, and the value is irrelevant anyway
  // because the same condition raises a stall and bubbles ID/EX.
  function automatic fwd_sel_t pickSource(input logic used,
                                          input logic e_hit,
                                          input logic e_load,
                                          input logic m_hit,
                                          input logic m_load);
    fwd_sel_t sel;
    sel = FWD_REGFILE;
    if (used) begin
      if (e_hit && !e_load) begin
        sel = FWD_EX_ALU;
      end else if (m_hit && !m_load) begin
        sel = FWD_MEM_ALU;
      end else if (m_hit && m_load) begin
        sel = FWD_MEM_LOAD;
      end
    end
    return sel;
  endfunction

  assign w_e_hit_rs = stageWrites(r_e_wreg, r_e_dest, i_d_rs);
  assign w_e_hit_rt = stageWrites(r_e_wreg, r_e_dest, i_d_rt);
  assign w_m_hit_rs = stageWrites(r_m_wreg, r_m_dest, i_d_rs);
  assign w_m_hit_rt = stageWrites(r_m_wreg, r_m_dest, i_d_rt);

  // A load still in EX has no data yet; the dependent instruction waits one
  // cycle and then picks the loaded value up from MEM.
  assign w_load_use_rs = r_e_m2reg && i_d_use_rs && w_e_hit_rs;
  assign w_load_use_rt = r_e_m2reg && i_d_use_rt && w_e_hit_rt;
  assign w_stall       = w_load_use_rs || w_load_use_rt;

  // The pipeline only moves when not frozen; a stall during freeze waits and
  // is re-evaluated after the freeze lifts.
  assign w_advance = !i_freeze;
  assign w_cnt_sat = &r_stall_count;

  // Operand select decode for rs and rt, evaluated independently so an
  // instruction reading the same register twice gets both selects.
  always_comb begin
    w_fwda = FWD_REGFILE;
    w_fwdb = FWD_REGFILE;
    w_fwda = pickSource(i_d_use_rs, w_e_hit_rs, r_e_m2reg, w_m_hit_rs, r_m_m2reg);
    w_fwdb = pickSource(i_d_use_rt, w_e_hit_rt, r_e_m2reg, w_m_hit_rt, r_m_m2reg);
  end

  // Tracking pipeline advance. On a stall, ID stays put and EX receives a
  // bubble (all-zero record) so the load moves ahead alone.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_e_dest  <= 5'd0;
      r_e_wreg  <= 1'b0;
      r_e_m2reg <= 1'b0;
      r_m_dest  <= 5'd0;
      r_m_wreg  <= 1'b0;
      r_m_m2reg <= 1'b0;
      r_w_dest  <= 5'd0;
      r_w_wreg  <= 1'b0;
      r_w_m2reg <= 1'b0;
    end else if (w_advance) begin
      r_w_dest  <= r_m_dest;
      r_w_wreg  <= r_m_wreg;
      r_w_m2reg <= r_m_m2reg;
      r_m_dest  <= r_e_dest;
      r_m_wreg  <= r_e_wreg;
      r_m_m2reg <= r_e_m2reg;
      if (w_stall) begin
        r_e_dest  <= 5'd0;
        r_e_wreg  <= 1'b0;
        r_e_m2reg <= 1'b0;
      end else begin
        r_e_dest  <= i_d_dest;
        r_e_wreg  <= i_d_wreg;
        r_e_m2reg <= i_d_m2reg;
      end
    end
  end

  // Stall-cycle counter: counts only stalls that actually cost a cycle
  // (not frozen) and sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_stall_count <= '0;
    end else if (w_advance && w_stall && !w_cnt_sat) begin
      r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

  assign o_fwda        = w_fwda;
  assign o_fwdb        = w_fwdb;
  assign o_stall       = w_stall;
  assign o_pc_wen      = !(w_stall || i_freeze);
  assign o_ifid_wen    = !(w_stall || i_freeze);
  assign o_e_bubble    = w_stall && !i_freeze;
  assign o_stall_count = r_stall_count;
  assign o_w_dest      = r_w_dest;
  assign o_w_wreg      = r_w_wreg;
  assign o_w_m2reg     = r_w_m2reg;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//
// Directed and randomized checks of hazard_fwd_ctrl. Two instances share the
// same stimulus: one with the default 16-bit stall counter and one with a
// 4-bit counter to reach saturation quickly. A reference model keeps the
// in-flight instruction records of EX/MEM/WB as a small array and derives the
// expected selects and stall from the pipeline rules directly.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       resetn;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] d_dest;
  logic       d_wreg;
  logic       d_m2reg;
  logic       d_use_rs;
  logic       d_use_rt;
  logic       freeze;

  logic [1:0]  fwda, fwdb;
  logic        stall, pc_wen, ifid_wen, e_bubble;
  logic [15:0] stall_count;
  logic [4:0]  w_dest;
  logic        w_wreg, w_m2reg;

  logic [1:0]  fwda4, fwdb4;
  logic        stall4, pc_wen4, ifid_wen4, e_bubble4;
  logic [3:0]  stall_count4;
  logic [4:0]  w_dest4;
  logic        w_wreg4, w_m2reg4;

  int nChecks = 0;
  int nErrors = 0;

  // Model state: index 0 = EX, 1 = MEM, 2 = WB
  typedef struct packed {
    logic [4:0] dest;
    logic       wreg;
    logic       m2reg;
  } stage_t;

  stage_t mdl [3];
  int     mdlCnt16;
  int     mdlCnt4;

  hazard_fwd_ctrl #(.STALL_CNT_W(16)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_d_rs(d_rs), .i_d_rt(d_rt), .i_d_dest(d_dest),
    .i_d_wreg(d_wreg), .i_d_m2reg(d_m2reg),
    .i_d_use_rs(d_use_rs), .i_d_use_rt(d_use_rt), .i_freeze(freeze),
    .o_fwda(fwda), .o_fwdb(fwdb), .o_stall(stall),
    .o_pc_wen(pc_wen), .o_ifid_wen(ifid_wen), .o_e_bubble(e_bubble),
    .o_stall_count(stall_count),
    .o_w_dest(w_dest), .o_w_wreg(w_wreg), .o_w_m2reg(w_m2reg)
  );

  hazard_fwd_ctrl #(.STALL_CNT_W(4)) dut4 (
    .i_clk(clk), .i_resetn(resetn),
    .i_d_rs(d_rs), .i_d_rt(d_rt), .i_d_dest(d_dest),
    .i_d_wreg(d_wreg), .i_d_m2reg(d_m2reg),
    .i_d_use_rs(d_use_rs), .i_d_use_rt(d_use_rt), .i_freeze(freeze),
    .o_fwda(fwda4), .o_fwdb(fwdb4), .o_stall(stall4),
    .o_pc_wen(pc_wen4), .o_ifid_wen(ifid_wen4), .o_e_bubble(e_bubble4),
    .o_stall_count(stall_count4),
    .o_w_dest(w_dest4), .o_w_wreg(w_wreg4), .o_w_m2reg(w_m2reg4)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // True when an in-flight instruction will deliver a new value of r
  function automatic logic writes(input stage_t s, input logic [4:0] r);
    return s.wreg && (s.dest == r) && (r != 5'd0);
  endfunction

  // Youngest ALU producer in EX first, then whatever MEM holds
  function automatic logic [1:0] modelFwd(input logic [4:0] r, input logic used);
    if (!used) return 2'b00;
    if (writes(mdl[0], r) && !mdl[0].m2reg) return 2'b01;
    if (writes(mdl[1], r)) return mdl[1].m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic modelStall();
    if (!mdl[0].m2reg) return 1'b0;
    return (d_use_rs && writes(mdl[0], d_rs)) || (d_use_rt && writes(mdl[0], d_rt));
  endfunction

  // One comparison: counts, and reports on mismatch
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one ID-stage instruction plus control inputs just after the
  // falling edge, then let combinational outputs settle
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] dest, input logic wreg,
                               input logic m2reg, input logic urs,
                               input logic urt, input logic frz,
                               input logic rstn);
    @(negedge clk);
    d_rs     = rs;
    d_rt     = rt;
    d_dest   = dest;
    d_wreg   = wreg;
    d_m2reg  = m2reg;
    d_use_rs = urs;
    d_use_rt = urt;
    freeze   = frz;
    resetn   = rstn;
    #1;
  endtask

  // Compare every output against the model, then advance the model to the
  // state it will have after the coming rising edge
  task automatic checkOutput();
    logic       expStall;
    logic [1:0] expA, expB;
    logic       expPc, expBub;
    expStall = modelStall();
    expA     = modelFwd(d_rs, d_use_rs);
    expB     = modelFwd(d_rt, d_use_rt);
    expPc    = !(expStall || freeze);
    expBub   = expStall && !freeze;
    checkVal("fwda", 32'(fwda), 32'(expA));
    checkVal("fwdb", 32'(fwdb), 32'(expB));
    checkVal("stall", 32'(stall), 32'(expStall));
    checkVal("pc_wen", 32'(pc_wen), 32'(expPc));
    checkVal("ifid_wen", 32'(ifid_wen), 32'(expPc));
    checkVal("e_bubble", 32'(e_bubble), 32'(expBub));
    checkVal("stall_count", 32'(stall_count), 32'(mdlCnt16));
    checkVal("wb_state", 32'({w_dest, w_wreg, w_m2reg}), 32'(mdl[2]));
    checkVal("dut4_ctrl", 32'({fwda4, fwdb4, stall4, pc_wen4, ifid_wen4, e_bubble4}),
             32'({expA, expB, expStall, expPc, expPc, expBub}));
    checkVal("dut4_stall_count", 32'(stall_count4), 32'(mdlCnt4));

    if (!resetn) begin
      for (int k = 0; k < 3; k++) mdl[k] = '0;
      mdlCnt16 = 0;
      mdlCnt4  = 0;
    end else if (!freeze) begin
      mdl[2] = mdl[1];
      mdl[1] = mdl[0];
      mdl[0] = expStall ? stage_t'('0) : stage_t'({d_dest, d_wreg, d_m2reg});
      if (expStall) begin
        if (mdlCnt16 < 65535) mdlCnt16++;
        if (mdlCnt4 < 15) mdlCnt4++;
      end
    end
  endtask

  // Plain model-checked cycle
  task automatic cycle(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dest, input logic wreg,
                       input logic m2reg, input logic urs, input logic urt,
                       input logic frz, input logic rstn);
    applyStimulus(rs, rt, dest, wreg, m2reg, urs, urt, frz, rstn);
    checkOutput();
    @(posedge clk);
  endtask

  initial begin
    resetn   = 1'b0;
    d_rs     = '0;
    d_rt     = '0;
    d_dest   = '0;
    d_wreg   = 1'b0;
    d_m2reg  = 1'b0;
    d_use_rs = 1'b0;
    d_use_rt = 1'b0;
    freeze   = 1'b0;

    // Power-on reset; outputs are undefined before the first reset edge
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) mdl[k] = '0;
    mdlCnt16 = 0;
    mdlCnt4  = 0;

    // Post-reset idle cycle
    applyStimulus(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("reset_stall", 32'(stall), 32'd0);
    checkVal("reset_pc_wen", 32'(pc_wen), 32'd1);
    checkVal("reset_count", 32'(stall_count), 32'd0);
    checkOutput();
    @(posedge clk);

    // ALU chain: add $3,$1,$2 ; sub $4,$3,$3 ; or $5,$3,$0
    cycle(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("alu_fwda_ex", 32'(fwda), 32'd1);
    checkVal("alu_fwdb_ex", 32'(fwdb), 32'd1);
    checkVal("alu_nostall", 32'(stall), 32'd0);
    checkOutput();
    @(posedge clk);
    applyStimulus(5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("alu_fwda_mem", 32'(fwda), 32'd2);
    checkOutput();
    @(posedge clk);

    // Load-use: lw $8,0($1) ; add $9,$8,$2 (held in ID for the stall)
    cycle(5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("lu_stall", 32'(stall), 32'd1);
    checkVal("lu_bubble", 32'(e_bubble), 32'd1);
    checkVal("lu_pc_wen", 32'(pc_wen), 32'd0);
    checkVal("lu_ifid_wen", 32'(ifid_wen), 32'd0);
    checkOutput();
    @(posedge clk);
    applyStimulus(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("lu_fwda_load", 32'(fwda), 32'd3);
    checkVal("lu_released", 32'(stall), 32'd0);
    checkVal("lu_count", 32'(stall_count), 32'd1);
    checkOutput();
    @(posedge clk);

    // $0 is never a producer: lw $0 then a reader of $0
    cycle(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("zero_nostall", 32'(stall), 32'd0);
    checkVal("zero_fwda", 32'(fwda), 32'd0);
    checkOutput();
    @(posedge clk);

    // Matching rt that is not read: add $10 then rt=$10 with use_rt=0
    cycle(5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd10, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkVal("unused_rt_fwdb", 32'(fwdb), 32'd0);
    checkOutput();
    @(posedge clk);

    // EX and MEM both write $7: EX wins
    cycle(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(5'd2, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'd7, 5'd7, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("prio_fwda", 32'(fwda), 32'd1);
    checkVal("prio_fwdb", 32'(fwdb), 32'd1);
    checkOutput();
    @(posedge clk);

    // Load-use while frozen for three cycles, then released
    cycle(5'd1, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      applyStimulus(5'd12, 5'd3, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      checkVal("frz_stall", 32'(stall), 32'd1);
      checkVal("frz_bubble", 32'(e_bubble), 32'd0);
      checkVal("frz_count", 32'(stall_count), 32'd1);
      checkOutput();
      @(posedge clk);
    end
    applyStimulus(5'd12, 5'd3, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("unfrz_bubble", 32'(e_bubble), 32'd1);
    checkOutput();
    @(posedge clk);
    applyStimulus(5'd12, 5'd3, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("unfrz_released", 32'(stall), 32'd0);
    checkVal("unfrz_count", 32'(stall_count), 32'd2);
    checkOutput();
    @(posedge clk);

    // Mid-stream reset with a load to $5 in EX
    cycle(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("midrst_stall", 32'(stall), 32'd0);
    checkVal("midrst_fwda", 32'(fwda), 32'd0);
    checkVal("midrst_fwdb", 32'(fwdb), 32'd0);
    checkVal("midrst_count", 32'(stall_count), 32'd0);
    checkVal("midrst_pc_wen", 32'(pc_wen), 32'd1);
    checkOutput();
    @(posedge clk);

    // Twenty load-use stalls: 4-bit counter must stick at 15
    for (int n = 0; n < 20; n++) begin
      cycle(5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("sat_count4", 32'(stall_count4), 32'd15);
    checkVal("sat_count16", 32'(stall_count), 32'd20);
    checkOutput();
    @(posedge clk);

    // Randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      cycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 49) != 0));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
